qact_pipe: RTL and testbench

Pipelined, back-pressured quantized activation stage for N parallel lanes. It replaces the purely combinational activation path between accumulator output and the next layer's input buffer. It applies ReLU or shift-based leaky-ReLU per beat, round-half-up rescaling and saturation, and optionally counts saturating beats. It streams one beat per cycle behind a valid/ready handshake with a fixed 3-cycle latency.

---
 rtl/qact_pipe.sv | 192 +++++++++++++++++++
 tb/tb_qact_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qact_pipe.sv
// qact_pipe: three-stage, back-pressured quantized activation for N lanes.
//   S1: ReLU / shift-based leaky-ReLU (arithmetic shift floors)
//   S2: round-half-up rescale by SH = XBF-YBF fractional bits
//   S3: saturate to YBQ bits (unsigned in ReLU mode, signed in leaky mode)
// Optional feature macro: QACT_SAT_CNT_EN builds the saturating-beat counter
// and its synchronous clear; without it sat_cnt reads 0 and sat_clr is ignored.
module qact_pipe #(
  parameter int N         = 1,
  parameter int XB        = 8,
  parameter int XBF       = 1,
  parameter int YBQ       = 8,
  parameter int YBF       = 0,
  parameter int NEG_SHIFT = 2,
  parameter int CB        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N*XB-1:0]  s_data,
  input  logic             s_mode,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N*YBQ-1:0] m_data,
  output logic             m_last,
  output logic [N-1:0]     m_sat,
  input  logic             sat_clr,
  output logic [CB-1:0]    sat_cnt
);

  localparam int SH = XBF - YBF;
  localparam int RW = XB + 1;
  localparam int CW = ((RW > YBQ + 1) ? RW : YBQ + 1) + 1;

  localparam logic [RW-1:0]        HALF = RW'(1) << (SH - 1);
  localparam logic signed [CW-1:0] UMAX = {{(CW-YBQ){1'b0}}, {YBQ{1'b1}}};
  localparam logic signed [CW-1:0] SMAX = {{(CW-YBQ+1){1'b0}}, {(YBQ-1){1'b1}}};
  localparam logic signed [CW-1:0] SMIN = {{(CW-YBQ+1){1'b1}}, {(YBQ-1){1'b0}}};

  if (SH < 1) begin : g_sh_check
    $error("qact_pipe: XBF-YBF must be at least 1");
  end
  if (NEG_SHIFT < 1 || NEG_SHIFT > XB - 1) begin : g_ns_check
    $error("qact_pipe: NEG_SHIFT must lie in 1..XB-1");
  end

  // Activation: pass non-negative values, otherwise zero or x * 2^-NEG_SHIFT.
  function automatic logic signed [XB-1:0] f_pre(input logic signed [XB-1:0] x,
                                                 input logic md);
    if (!x[XB-1]) return x;
    if (md)       return x >>> NEG_SHIFT;
    return '0;
  endfunction

  // Round half up and drop SH fractional bits; one guard bit prevents overflow.
  function automatic logic signed [RW-1:0] f_round(input logic signed [XB-1:0] p);
    logic signed [RW-1:0] sum;
    sum = {p[XB-1], p} + HALF;
    return sum >>> SH;
  endfunction

  // Clip to the output range of the beat's mode; MSB of the result is the sat flag.
  function automatic logic [YBQ:0] f_clip(input logic signed [RW-1:0] r,
                                          input logic md);
    logic signed [CW-1:0] rc;
    rc = {{(CW-RW){r[RW-1]}}, r};
    if (!md) begin
      if (rc > UMAX) return {1'b1, UMAX[YBQ-1:0]};
      return {1'b0, rc[YBQ-1:0]};
    end
    if (rc > SMAX) return {1'b1, SMAX[YBQ-1:0]};
    if (rc < SMIN) return {1'b1, SMIN[YBQ-1:0]};
    return {1'b0, rc[YBQ-1:0]};
  endfunction

  // Stage state
  logic                 v1, v2, v3;
  logic                 m1, m2;
  logic                 l1, l2;
  logic signed [XB-1:0] pre1 [N];
  logic signed [RW-1:0] r2   [N];

  // Handshake chain: a stage advances only when its successor can load, so a
  // full pipeline with m_ready high still accepts a beat every cycle.
  logic ld1, ld2, ld3;
  logic adv1, adv2, adv3;

  assign adv3    = v3 & m_ready;
  assign ld3     = v2 & (~v3 | adv3);
  assign adv2    = ld3;
  assign ld2     = v1 & (~v2 | adv2);
  assign adv1    = ld2;
  assign s_ready = ~v1 | adv1;
  assign ld1     = s_valid & s_ready;
  assign m_valid = v3;

  // Next S3 contents, computed from the S2 register
  logic [N*YBQ-1:0] y_nxt;
  logic [N-1:0]     sat_nxt;

  // Per-lane saturation of the rounded S2 values
  always_comb begin
    logic [YBQ:0] c;
    y_nxt   = '0;
    sat_nxt = '0;
    c       = '0;
    for (int unsigned n = 0; n < N; n++) begin
      c                    = f_clip(r2[n], m2);
      y_nxt[n*YBQ +: YBQ]  = c[YBQ-1:0];
      sat_nxt[n]           = c[YBQ];
    end
  end

  // Stage valid bits: set on load, cleared when the beat moves on
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1)       v1 <= 1'b1;
      else if (adv1) v1 <= 1'b0;
      if (ld2)       v2 <= 1'b1;
      else if (adv2) v2 <= 1'b0;
      if (ld3)       v3 <= 1'b1;
      else if (adv3) v3 <= 1'b0;
    end
  end

  // S1: capture activation result with the beat's mode and last flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m1 <= 1'b0;
      l1 <= 1'b0;
      for (int unsigned n = 0; n < N; n++) pre1[n] <= '0;
    end else if (ld1) begin
      m1 <= s_mode;
      l1 <= s_last;
      for (int unsigned n = 0; n < N; n++) pre1[n] <= f_pre(s_data[n*XB +: XB], s_mode);
    end
  end

  // S2: capture rounded, rescaled values
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m2 <= 1'b0;
      l2 <= 1'b0;
      for (int unsigned n = 0; n < N; n++) r2[n] <= '0;
    end else if (ld2) begin
      m2 <= m1;
      l2 <= l1;
      for (int unsigned n = 0; n < N; n++) r2[n] <= f_round(pre1[n]);
    end
  end

  // S3: output register; holds while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data <= '0;
      m_sat  <= '0;
      m_last <= 1'b0;
    end else if (ld3) begin
      m_data <= y_nxt;
      m_sat  <= sat_nxt;
      m_last <= l2;
    end
  end

`ifdef QACT_SAT_CNT_EN
  logic [CB-1:0] cnt;

  // Count output handshakes carrying any saturated lane; clear wins, no wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (sat_clr) begin
      cnt <= '0;
    end else if (adv3 && (|m_sat) && (cnt != '1)) begin
      cnt <= cnt + CB'(1);
    end
  end

  assign sat_cnt = cnt;
`else
  logic unused_sat_clr;

  assign unused_sat_clr = sat_clr;
  assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_qact_pipe.sv
// Self-checking bench for qact_pipe (N=1, XB=8, XBF=4, YBQ=4, YBF=2, NEG_SHIFT=2, CB=2).
// Expected beats are pushed to a scoreboard queue on input handshake and
// compared on output handshake; scenario tasks add inline checks.
module tb_qact_pipe;

  logic       clk = 1'b0;
  logic       rstn;
  logic       s_valid, s_ready, s_mode, s_last;
  logic [7:0] s_data;
  logic       m_valid, m_ready, m_last;
  logic [3:0] m_data;
  logic [0:0] m_sat;
  logic       sat_clr;
  logic [1:0] sat_cnt;

  int vecs = 0;
  int errs = 0;

  // Scoreboard entries: {last, sat, y[3:0]}
  logic [5:0] q [$];
  logic       held_v = 1'b0;
  logic [5:0] held, got, e;

  qact_pipe #(
    .N(1), .XB(8), .XBF(4), .YBQ(4), .YBF(2), .NEG_SHIFT(2), .CB(2)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_sat(m_sat),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  // Reference: floor divisions done on integers, then clip to the mode's range.
  function automatic logic [4:0] model(input logic [7:0] xb, input logic md);
    int x, pre, r, y;
    logic sat;
    x = $signed(xb);
    if (x >= 0)   pre = x;
    else if (md)  pre = -((-x + 3) / 4);
    else          pre = 0;
    r = pre + 2;
    r = (r >= 0) ? r / 4 : -((-r + 3) / 4);
    sat = 1'b0;
    y = r;
    if (!md) begin
      if (r > 15) begin y = 15; sat = 1'b1; end
    end else begin
      if (r > 7)       begin y = 7;  sat = 1'b1; end
      else if (r < -8) begin y = -8; sat = 1'b1; end
    end
    return {sat, 4'(y)};
  endfunction

  // Mid-cycle monitor: occupancy vs s_ready, stall stability, scoreboard.
  always @(negedge clk) begin
    if (!rstn) begin
      held_v = 1'b0;
    end else begin
      vecs++;
      if (s_ready !== !(q.size() == 3 && !m_ready)) begin
        errs++;
        $display("FAIL s_ready_occupancy: got %b want %b (in flight %0d, m_ready %b)",
                 s_ready, !(q.size() == 3 && !m_ready), q.size(), m_ready);
      end
      got = {m_last, m_sat, m_data};
      if (held_v) begin
        vecs++;
        if (m_valid !== 1'b1 || got !== held) begin
          errs++;
          $display("FAIL stall_hold: got v=%b %h want v=1 %h", m_valid, got, held);
        end
      end
      held_v = m_valid && !m_ready;
      held   = got;
      if (m_valid && m_ready) begin
        vecs++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL scoreboard_extra: got %h want no beat", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errs++;
            $display("FAIL scoreboard_beat: got {last,sat,y}=%h want %h", got, e);
          end
        end
      end
      if (s_valid && s_ready) q.push_back({s_last, model(s_data, s_mode)});
    end
  end

  task automatic send(input logic [7:0] x, input logic md, input logic lst, output int waits);
    logic acc;
    s_valid = 1'b1; s_data = x; s_mode = md; s_last = lst;
    waits = 0; acc = 1'b0;
    while (!acc && waits < 100) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      vecs++; errs++;
      $display("FAIL send_timeout: beat %h accepted=%b want 1 within 100 cycles", x, acc);
    end
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", q.size());
    end
    vecs++;
    if (m_valid !== 1'b0) begin
      errs++;
      $display("FAIL drain_idle: got m_valid=%b want 0", m_valid);
    end
  endtask

  // Latency counted from the handshake cycle to the cycle m_valid is seen.
  task automatic lat_beat(input logic [7:0] x, input logic md,
                          output int lat, output logic [3:0] y, output logic sat);
    int w;
    m_ready = 1'b1;
    send(x, md, 1'b0, w);
    lat = 1;
    while (!m_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    y = m_data; sat = m_sat[0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    vecs++; if (m_data !== 4'h0)  begin errs++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    vecs++; if (m_last !== 1'b0)  begin errs++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    vecs++; if (m_sat !== 1'b0)   begin errs++; $display("FAIL reset_m_sat: got %b want 0", m_sat); end
    vecs++; if (sat_cnt !== 2'd0) begin errs++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_relu();
    logic [7:0] xs [3]  = '{8'h13, 8'h7F, 8'hF8};
    logic [3:0] ys [3]  = '{4'd5, 4'd15, 4'd0};
    logic       ss [3]  = '{1'b0, 1'b1, 1'b0};
    int lat; logic [3:0] y; logic sat;
    for (int i = 0; i < 3; i++) begin
      lat_beat(xs[i], 1'b0, lat, y, sat);
      vecs++; if (lat !== 3)     begin errs++; $display("FAIL relu_latency x=%h: got %0d want 3", xs[i], lat); end
      vecs++; if (y !== ys[i])   begin errs++; $display("FAIL relu_y x=%h: got %h want %h", xs[i], y, ys[i]); end
      vecs++; if (sat !== ss[i]) begin errs++; $display("FAIL relu_sat x=%h: got %b want %b", xs[i], sat, ss[i]); end
    end
    drain();
  endtask

  task automatic test_leaky();
    logic [7:0] xs [4]  = '{8'hEC, 8'h80, 8'h64, 8'h13};
    logic [3:0] ys [4]  = '{4'hF, 4'h8, 4'h7, 4'h5};
    logic       ss [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [3:0] y; logic sat;
    for (int i = 0; i < 4; i++) begin
      lat_beat(xs[i], 1'b1, lat, y, sat);
      vecs++; if (lat !== 3)     begin errs++; $display("FAIL leaky_latency x=%h: got %0d want 3", xs[i], lat); end
      vecs++; if (y !== ys[i])   begin errs++; $display("FAIL leaky_y x=%h: got %h want %h", xs[i], y, ys[i]); end
      vecs++; if (sat !== ss[i]) begin errs++; $display("FAIL leaky_sat x=%h: got %b want %b", xs[i], sat, ss[i]); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'(i * 37 - 100), 1'(i % 2), (i == 7), w);
      vecs++;
      if (w !== 0) begin errs++; $display("FAIL b2b_throughput beat %0d: got %0d wait cycles want 0", i, w); end
    end
    drain();
  endtask

  task automatic test_full_stall();
    int w;
    m_ready = 1'b0;
    send(8'h13, 1'b0, 1'b0, w);
    send(8'hEC, 1'b1, 1'b0, w);
    send(8'h7F, 1'b0, 1'b1, w);
    s_valid = 1'b1; s_data = 8'h80; s_mode = 1'b1; s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL full_s_ready: got %b want 0", s_ready); end
      vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL full_m_valid: got %b want 1", m_valid); end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL full_swap_m_valid: got %b want 1", m_valid); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_backpressure();
    bit done = 1'b0;
    int w;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), (i % 4 == 3), w);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 2) == 0);
        end
      end
    join
    drain();
  endtask

  task automatic test_counter();
    int w, n;
    m_ready = 1'b1;
`ifdef QACT_SAT_CNT_EN
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    vecs++; if (sat_cnt !== 2'd0) begin errs++; $display("FAIL cnt_clear: got %0d want 0", sat_cnt); end
    for (int i = 0; i < 5; i++) send(8'h7F, 1'b0, 1'b0, w);
    drain();
    vecs++; if (sat_cnt !== 2'd3) begin errs++; $display("FAIL cnt_saturate: got %0d want 3", sat_cnt); end
    send(8'h13, 1'b0, 1'b0, w);
    drain();
    vecs++; if (sat_cnt !== 2'd3) begin errs++; $display("FAIL cnt_hold: got %0d want 3", sat_cnt); end
    send(8'h64, 1'b1, 1'b0, w);
    n = 0;
    while (!m_valid && n < 10) begin @(posedge clk); #1; n++; end
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    vecs++; if (sat_cnt !== 2'd0) begin errs++; $display("FAIL cnt_clr_priority: got %0d want 0", sat_cnt); end
    drain();
`else
    for (int i = 0; i < 5; i++) send(8'h7F, 1'b0, 1'b0, w);
    drain();
    vecs++; if (sat_cnt !== 2'd0) begin errs++; $display("FAIL cnt_disabled: got %0d want 0", sat_cnt); end
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    vecs++; if (sat_cnt !== 2'd0) begin errs++; $display("FAIL cnt_disabled_clr: got %0d want 0", sat_cnt); end
    n = 0;
`endif
  endtask

  task automatic test_reset_midstream();
    int w, lat;
    logic [3:0] y; logic sat;
    m_ready = 1'b1;
    send(8'h7F, 1'b0, 1'b0, w);
    drain();
    m_ready = 1'b0;
    send(8'h13, 1'b0, 1'b0, w);
    send(8'h64, 1'b1, 1'b0, w);
    send(8'hEC, 1'b1, 1'b1, w);
    vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL midrst_pre_valid: got %b want 1", m_valid); end
    #2 rstn = 1'b0;
    #1;
    q.delete();
    vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    vecs++; if (m_data !== 4'h0)  begin errs++; $display("FAIL midrst_m_data: got %h want 0", m_data); end
    vecs++; if (sat_cnt !== 2'd0) begin errs++; $display("FAIL midrst_sat_cnt: got %0d want 0", sat_cnt); end
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL midrst_s_ready: got %b want 1", s_ready); end
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL midrst_ghost cycle %0d: got m_valid=%b want 0", i, m_valid); end
    end
    lat_beat(8'h13, 1'b0, lat, y, sat);
    vecs++; if (lat !== 3)    begin errs++; $display("FAIL midrst_first_latency: got %0d want 3", lat); end
    vecs++; if (y !== 4'd5)   begin errs++; $display("FAIL midrst_first_y: got %h want 5", y); end
    drain();
  endtask

  initial begin
    rstn = 1'b1; s_valid = 1'b0; s_data = '0; s_mode = 1'b0; s_last = 1'b0;
    m_ready = 1'b1; sat_clr = 1'b0;
    test_reset();
    test_relu();
    test_leaky();
    test_back_to_back();
    test_full_stall();
    test_backpressure();
    test_counter();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d vectors, want completion", vecs);
    $fatal(1, "watchdog");
  end

endmodule
